pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer: a two-state RUN/HALTED controller that picks the
// next PC from increment, branch, jump or hold, and drives the downstream mux select.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  ST_RUN    | pc advances each edge by the selected source (inc/branch/jump/hold)
//  ST_HALTED | pc frozen, next_sel forced to hold until resume without halt
module pc_sequencer #(
  parameter int               size         = 16,
  parameter logic [size-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [size-1:0] branch_target,
  input  logic            jump,
  input  logic [size-1:0] jump_target,
  input  logic            halt,
  input  logic            resume,
  output logic [size-1:0] pc,
  output logic [size-1:0] pc_plus1,
  output logic [1:0]      next_sel,
  output logic            running
);

  localparam logic [1:0] SEL_INC    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;
  localparam logic [1:0] SEL_HOLD   = 2'd3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t state;

  assign pc_plus1 = pc + size'(1);
  assign running  = (state == ST_RUN);

  // Priority: halted/halt > stall > jump > branch > increment.
  always_comb begin
    next_sel = SEL_INC;
    if (state == ST_HALTED) begin
      next_sel = SEL_HOLD;
    end else if (halt) begin
      next_sel = SEL_HOLD;
    end else if (stall) begin
      next_sel = SEL_HOLD;
    end else if (jump) begin
      next_sel = SEL_JUMP;
    end else if (branch_taken) begin
      next_sel = SEL_BRANCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_VECTOR;
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt) begin
            state <= ST_HALTED;
          end
          case (next_sel)
            SEL_INC:    pc <= pc_plus1;
            SEL_BRANCH: pc <= branch_target;
            SEL_JUMP:   pc <= jump_target;
            default:    pc <= pc;
          endcase
        end
        ST_HALTED: begin
          // halt wins over a simultaneous resume
          if (resume && !halt) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule
